// File: rtl/path_tracer.sv
// +------------------------------------------------------------------------+
// | path_tracer: walks a predecessor map from dest_node back to source_node |
// | and streams the path over valid/ready. Optional PATH_TRACER_REVERSE_EN  |
// | buffers the walk in a stack and streams source-first.                   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef UNVISITED
`define UNVISITED '1
`endif

module path_tracer #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INDEX_WIDTH-1:0]           source_node,
  input  logic [INDEX_WIDTH-1:0]           dest_node,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  output logic [INDEX_WIDTH-1:0]           path_node,
  output logic                             path_valid,
  input  logic                             path_ready,
  output logic                             path_last,
  output logic [INDEX_WIDTH:0]             path_length,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int                   c_stw       = $clog2(MAX_NODES + 1);
  localparam logic [c_stw-1:0]     c_max_steps = c_stw'(MAX_NODES);
  localparam logic [INDEX_WIDTH:0] c_max_nodes = (INDEX_WIDTH + 1)'(MAX_NODES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_EMIT   = 3'd2,
    S_FINISH = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [INDEX_WIDTH-1:0] r_cur;
  logic [INDEX_WIDTH-1:0] r_src;
  logic [c_stw-1:0]       r_steps;
  logic [INDEX_WIDTH-1:0] w_prev_cur;
  logic                   w_check_ok;
  logic                   w_at_src;
  logic                   w_fire;

  // Predecessor of the current node, read from the live map.
  always_comb begin
    w_prev_cur = '0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (r_cur == INDEX_WIDTH'(j)) begin
        w_prev_cur = prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH];
      end
    end
  end

  assign w_at_src   = (r_cur == r_src);
  assign w_check_ok = ({1'b0, r_cur} < c_max_nodes) &&
                      (r_steps != c_max_steps) &&
                      (w_at_src || (w_prev_cur != `UNVISITED));
  assign w_fire     = path_valid && path_ready;

`ifdef PATH_TRACER_REVERSE_EN
  logic [INDEX_WIDTH-1:0] r_stack [MAX_NODES];
  logic [INDEX_WIDTH-1:0] w_top;

  // r_steps doubles as the stack pointer: it counts pushes, then pops.
  always_comb begin
    w_top = '0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (r_steps == c_stw'(j + 1)) begin
        w_top = r_stack[j];
      end
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (!w_check_ok) begin
          w_state_next = S_FAIL;
`ifdef PATH_TRACER_REVERSE_EN
        end else if (w_at_src) begin
          w_state_next = S_EMIT;
`else
        end else begin
          w_state_next = S_EMIT;
`endif
        end
      end
      S_EMIT: begin
        if (w_fire && path_last) begin
          w_state_next = S_FINISH;
`ifndef PATH_TRACER_REVERSE_EN
        end else if (w_fire) begin
          w_state_next = S_CHECK;
`endif
        end
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      S_FAIL: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cur       <= '0;
      r_src       <= '0;
      r_steps     <= '0;
      path_node   <= '0;
      path_valid  <= 1'b0;
      path_last   <= 1'b0;
      path_length <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur       <= dest_node;
            r_src       <= source_node;
            r_steps     <= '0;
            path_length <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_check_ok) begin
`ifdef PATH_TRACER_REVERSE_EN
            r_steps <= r_steps + c_stw'(1);
            if (!w_at_src) r_cur <= w_prev_cur;
`else
            path_node  <= r_cur;
            path_valid <= 1'b1;
            path_last  <= w_at_src;
`endif
          end
        end
        S_EMIT: begin
          if (w_fire) begin
            path_valid  <= 1'b0;
            path_last   <= 1'b0;
            path_length <= path_length + (INDEX_WIDTH + 1)'(1);
`ifndef PATH_TRACER_REVERSE_EN
            r_steps     <= r_steps + c_stw'(1);
            if (!path_last) r_cur <= w_prev_cur;
`endif
          end
`ifdef PATH_TRACER_REVERSE_EN
          // Pop the next node once the previous beat has been taken.
          else if (!path_valid && (r_steps != '0)) begin
            path_node  <= w_top;
            path_valid <= 1'b1;
            path_last  <= (r_steps == c_stw'(1));
            r_steps    <= r_steps - c_stw'(1);
          end
`endif
        end
        S_FINISH: begin
          busy <= 1'b0;
        end
        S_FAIL: begin
          busy       <= 1'b0;
          error      <= 1'b1;
          path_valid <= 1'b0;
          path_last  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef PATH_TRACER_REVERSE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < MAX_NODES; j++) r_stack[j] <= '0;
    end else if ((r_state == S_CHECK) && w_check_ok) begin
      for (int j = 0; j < MAX_NODES; j++) begin
        if (r_steps == c_stw'(j)) r_stack[j] <= r_cur;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_path_tracer.sv
// Bench for path_tracer: table of traces with a beat scoreboard, plus reset sequences.
`default_nettype none

module tb_path_tracer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  source_node;
  logic [3:0]  dest_node;
  logic [31:0] prev_vector_flattened;
  logic [3:0]  path_node;
  logic        path_valid;
  logic        path_ready;
  logic        path_last;
  logic [4:0]  path_length;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  path_tracer #(.MAX_NODES(8), .INDEX_WIDTH(4)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .source_node           (source_node),
    .dest_node             (dest_node),
    .prev_vector_flattened (prev_vector_flattened),
    .path_node             (path_node),
    .path_valid            (path_valid),
    .path_ready            (path_ready),
    .path_last             (path_last),
    .path_length           (path_length),
    .busy                  (busy),
    .done                  (done),
    .error                 (error)
  );

  typedef struct {
    logic [31:0] map;
    logic [3:0]  src;
    logic [3:0]  dest;
    int          stall;
    int          nb;
    logic [31:0] beats;   // beat k in nibble k
    logic [4:0]  len;
    logic        err;
  } vec_t;

  localparam logic [31:0] MAP_A = 32'hFF2F50F0;  // 0<-0, 2<-0, 5<-2, 3<-5
  localparam logic [31:0] MAP_B = 32'hFF215040;  // MAP_A plus 1<->4 loop

  vec_t       vecs [8];
  logic [4:0] sb_q [$];   // {last, node}
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc;
    int         first_v;
    int         last_hs;
    int         prev_hs;
    int         wait_cnt;
    int         nbeats;
    bit         seen_done;
    bit         stalled;
    logic [4:0] held;
    logic [4:0] exp;
    prev_vector_flattened = v.map;
    source_node = v.src;
    dest_node   = v.dest;
    path_ready  = 1'b0;
    for (int k = 0; k < v.nb; k++)
      sb_q.push_back({(!v.err && (k == v.nb - 1)), v.beats[4*k +: 4]});
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1);
    chk("error_cleared", error, 0);
    chk("length_cleared", path_length, 0);
    first_v = -1; last_hs = -1; prev_hs = -1; wait_cnt = 0;
    nbeats = 0; seen_done = 0; stalled = 0; held = '0;
    while (!seen_done && cyc < 300) begin
      if (stalled) begin
        chk("hold_valid", path_valid, 1);
        chk("hold_beat", {path_last, path_node}, held);
        stalled = 0;
      end
      if (done) begin
        seen_done = 1;
        if (!v.err && last_hs >= 0) chk("done_latency", cyc - last_hs, 1);
      end
      if (path_valid) begin
        if (first_v < 0) begin
          first_v = cyc;
          chk("first_valid_latency", cyc, 2);
        end
        if (wait_cnt < v.stall) begin
          path_ready = 1'b0; wait_cnt++;
        end else begin
          path_ready = 1'b1; wait_cnt = 0;
        end
      end else begin
        path_ready = 1'b0;
      end
      if (path_valid && path_ready) begin
        if (sb_q.size() == 0) begin
          chk("extra_beat", {path_last, path_node}, 5'h1F);
          chk("extra_beat_count", nbeats + 1, v.nb);
        end else begin
          exp = sb_q.pop_front();
          chk("beat", {path_last, path_node}, exp);
        end
        if (v.stall == 0 && prev_hs >= 0) chk("throughput", cyc - prev_hs, 2);
        prev_hs = cyc; last_hs = cyc; nbeats++;
      end else if (path_valid) begin
        stalled = 1;
        held = {path_last, path_node};
      end
      if (!seen_done) begin
        @(negedge clock);
        cyc++;
      end
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    path_ready = 1'b0;
    @(negedge clock);
    chk("done_single_pulse", done, 0);
    chk("busy_end", busy, 0);
    chk("error_flag", error, v.err);
    chk("path_length", path_length, v.len);
    chk("beat_count", nbeats, v.nb);
    chk("scoreboard_empty", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    vecs[0] = '{map: MAP_A, src: 4'd0, dest: 4'd3, stall: 0, nb: 4, beats: 32'h0253,     len: 5'd4, err: 1'b0};
    vecs[1] = '{map: MAP_A, src: 4'd0, dest: 4'd3, stall: 3, nb: 4, beats: 32'h0253,     len: 5'd4, err: 1'b0};
    vecs[2] = '{map: MAP_A, src: 4'd0, dest: 4'd6, stall: 0, nb: 0, beats: 32'h0,        len: 5'd0, err: 1'b1};
    vecs[3] = '{map: MAP_B, src: 4'd0, dest: 4'd1, stall: 0, nb: 8, beats: 32'h41414141, len: 5'd8, err: 1'b1};
    vecs[4] = '{map: MAP_A, src: 4'd2, dest: 4'd2, stall: 0, nb: 1, beats: 32'h2,        len: 5'd1, err: 1'b0};
    vecs[5] = '{map: MAP_A, src: 4'd0, dest: 4'd5, stall: 1, nb: 3, beats: 32'h025,      len: 5'd3, err: 1'b0};
    vecs[6] = '{map: MAP_A, src: 4'd0, dest: 4'd9, stall: 0, nb: 0, beats: 32'h0,        len: 5'd0, err: 1'b1};
    vecs[7] = '{map: MAP_A, src: 4'd3, dest: 4'd0, stall: 2, nb: 8, beats: 32'h0,        len: 5'd8, err: 1'b1};

    reset = 1'b0; start = 1'b0; path_ready = 1'b0;
    source_node = '0; dest_node = '0; prev_vector_flattened = MAP_A;
    repeat (2) @(negedge clock);
    chk("reset_path_node", path_node, 0);
    chk("reset_path_valid", path_valid, 0);
    chk("reset_path_last", path_last, 0);
    chk("reset_path_length", path_length, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while a beat is pending, then a normal trace.
    prev_vector_flattened = MAP_A; source_node = 4'd0; dest_node = 4'd3; path_ready = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    chk("emit_reached", path_valid, 1);
    #2 reset = 1'b0;
    #1 chk("async_reset_outputs",
           {path_node, path_valid, path_last, path_length, busy, done, error}, 0);
    @(negedge clock);
    chk("reset_hold_outputs",
        {path_node, path_valid, path_last, path_length, busy, done, error}, 0);
    reset = 1'b1;
    @(negedge clock);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
